// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit: opcode fields, FSM state codes, mux select codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ctrl_pkg;

    // opcode[6:2] values of the supported instruction groups
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    // FETCH is code 0 so the reset-time state output reads as all zeros
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // instruction class latched at DECODE; CLS_NONE doubles as "illegal"
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_OPIMM  = 4'd7,
        CLS_STORE  = 4'd8,
        CLS_OP     = 4'd9
    } opclass_t;

    // next-PC source
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // ALU operand sources
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

    // register write-back source
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_opclass.sv
// Maps a 7-bit opcode to an instruction class and a legal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode directly.
module ctrl_opclass
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass,
    output logic       legal
);

    // anything without the 32-bit encoding marker or with an unknown major opcode is CLS_NONE
    always_comb begin
        opclass = CLS_NONE;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                OPC_LUI:    opclass = CLS_LUI;
                OPC_AUIPC:  opclass = CLS_AUIPC;
                OPC_JAL:    opclass = CLS_JAL;
                OPC_JALR:   opclass = CLS_JALR;
                OPC_BRANCH: opclass = CLS_BRANCH;
                OPC_LOAD:   opclass = CLS_LOAD;
                OPC_OPIMM:  opclass = CLS_OPIMM;
                OPC_STORE:  opclass = CLS_STORE;
                OPC_OP:     opclass = CLS_OP;
                default:    opclass = CLS_NONE;
            endcase
        end
    end

    assign legal = (opclass != CLS_NONE);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller (FETCH/DECODE/EXEC/MEM/WB/HALT); CTRL_PERF_CNT_EN adds cycle/instret counters.
// Latency: branch 3, load 5, everything else 4 cycles at zero wait-states.
// Backpressure: FETCH holds on im_ready low, MEM holds on dm_ready low; requests stay asserted while held.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        im_req,
    output logic        ir_write,
    output logic        dm_req,
    output logic        dm_we,
    output logic        rf_we,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t   state_q;
    state_t   state_d;
    opclass_t cls_q;
    opclass_t dec_cls;
    logic     dec_legal;

    ctrl_opclass u_opclass (
        .opcode  (opcode),
        .opclass (dec_cls),
        .legal   (dec_legal)
    );

    // state register; class is captured on the single DECODE cycle and cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    // next-state: ready inputs only matter in their own wait state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = im_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                if (cls_q == CLS_BRANCH) begin
                    state_d = ST_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dm_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // output decode; everything forced low while rst is high so an abandoned instruction never retires
    always_comb begin
        im_req    = 1'b0;
        ir_write  = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_RS2;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;
        if (!rst) begin
            // operand selects stay valid through MEM/WB so the address and result stay stable
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                case (cls_q)
                    CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = ALU_B_IMM;
                    CLS_AUIPC: begin
                        alu_src_a = ALU_A_PC;
                        alu_src_b = ALU_B_IMM;
                    end
                    CLS_LUI: begin
                        alu_src_a = ALU_A_ZERO;
                        alu_src_b = ALU_B_IMM;
                    end
                    default: ;
                endcase
            end
            case (state_q)
                ST_FETCH: begin
                    im_req   = 1'b1;
                    ir_write = im_ready;
                end
                ST_EXEC: begin
                    if (cls_q == CLS_BRANCH) begin
                        pc_write = 1'b1;
                        pc_sel   = br_taken ? PC_IMM : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    dm_req = 1'b1;
                    dm_we  = (cls_q == CLS_STORE);
                    // a store retires on the cycle its memory access completes
                    if (dm_ready && cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we    = 1'b1;
                    pc_write = 1'b1;
                    if (cls_q == CLS_LOAD) begin
                        wb_sel = WB_MEM;
                    end else if (cls_q == CLS_JAL || cls_q == CLS_JALR) begin
                        wb_sel = WB_PC4;
                    end
                    if (cls_q == CLS_JAL) begin
                        pc_sel = PC_IMM;
                    end else if (cls_q == CLS_JALR) begin
                        pc_sel = PC_JALR;
                    end
                end
                ST_HALT: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = rst ? ST_FETCH : state_q;

`ifdef CTRL_PERF_CNT_EN
    // free-running performance counters; HALT cycles are not counted, wrap is natural
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_write) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level trace model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int K_ILL = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4;
    localparam int K_BR = 5, K_LD = 6, K_OPI = 7, K_ST = 8, K_OP = 9;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b0000001;

    logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                  7'b1100011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011};

    typedef struct packed {
        logic       im_req;
        logic       ir_write;
        logic       dm_req;
        logic       dm_we;
        logic       rf_we;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] alu_a;
        logic       alu_b;
        logic [1:0] wb_sel;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       im_ready;
        logic       dm_ready;
        logic       br_taken;
        logic       mark;
        logic [6:0] opcode;
        logic [2:0] st;
        obs_t       exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        br_taken, im_ready, dm_ready;
    logic        im_req, ir_write, dm_req, dm_we, rf_we, pc_write;
    logic [1:0]  pc_sel, alu_src_a, wb_sel;
    logic        alu_src_b, illegal;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    cyc_t trace[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .im_ready  (im_ready),
        .dm_ready  (dm_ready),
        .im_req    (im_req),
        .ir_write  (ir_write),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .rf_we     (rf_we),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .state     (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b1100011: return K_BR;
            7'b0000011: return K_LD;
            7'b0010011: return K_OPI;
            7'b0100011: return K_ST;
            7'b0110011: return K_OP;
            default:    return K_ILL;
        endcase
    endfunction

    // new cycle with all expected outputs low and don't-care inputs randomized
    function automatic cyc_t mk(input logic [6:0] op, input logic [2:0] st);
        cyc_t c;
        c          = '0;
        c.opcode   = op;
        c.st       = st;
        c.im_ready = 1'($urandom_range(0, 1));
        c.dm_ready = 1'($urandom_range(0, 1));
        c.br_taken = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic obs_t with_alu(input obs_t o, input int k);
        obs_t r;
        r = o;
        case (k)
            K_LUI:   begin r.alu_a = 2'd2; r.alu_b = 1'b1; end
            K_AUIPC: begin r.alu_a = 2'd1; r.alu_b = 1'b1; end
            K_OPI, K_LD, K_ST, K_JALR: r.alu_b = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // expected per-cycle trace of one instruction; abort>=0 replaces that cycle with a reset cycle
    task automatic expand(input logic [6:0] op, input int imw, input int dmw, input int br, input int abort);
        cyc_t q[$];
        cyc_t c;
        int   k;
        int   ab;
        k  = cls_of(op);
        ab = abort;
        for (int i = 0; i < imw; i++) begin
            c = mk(op, ST_FETCH); c.im_ready = 1'b0; c.exp.im_req = 1'b1; q.push_back(c);
        end
        c = mk(op, ST_FETCH); c.im_ready = 1'b1; c.exp.im_req = 1'b1; c.exp.ir_write = 1'b1; q.push_back(c);
        c = mk(op, ST_DECODE); q.push_back(c);
        if (k == K_ILL) begin
            for (int i = 0; i < 3; i++) begin
                c = mk(op, ST_HALT); c.exp.illegal = 1'b1; q.push_back(c);
            end
            if (ab < 0 || ab > q.size()) ab = q.size();
        end else begin
            c = mk(op, ST_EXEC);
            c.exp = with_alu(c.exp, k);
            if (br >= 0) c.br_taken = br[0];
            if (k == K_BR) begin
                c.exp.pc_write = 1'b1;
                c.exp.pc_sel   = c.br_taken ? 2'd1 : 2'd0;
            end
            q.push_back(c);
            if (k == K_LD || k == K_ST) begin
                for (int i = 0; i <= dmw; i++) begin
                    c = mk(op, ST_MEM);
                    c.dm_ready   = (i == dmw);
                    c.exp        = with_alu(c.exp, k);
                    c.exp.dm_req = 1'b1;
                    c.exp.dm_we  = (k == K_ST);
                    if (k == K_ST && i == dmw) c.exp.pc_write = 1'b1;
                    q.push_back(c);
                end
            end
            if (k != K_BR && k != K_ST) begin
                c = mk(op, ST_WB);
                c.exp          = with_alu(c.exp, k);
                c.exp.rf_we    = 1'b1;
                c.exp.pc_write = 1'b1;
                c.exp.wb_sel   = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
                c.exp.pc_sel   = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
                q.push_back(c);
            end
        end
        if (ab >= 0 && ab <= q.size()) begin
            while (q.size() > ab) void'(q.pop_back());
            c = mk(op, ST_FETCH); c.rst = 1'b1; q.push_back(c);
        end
        foreach (q[i]) trace.push_back(q[i]);
    endtask

    task automatic push_reset(input logic mark);
        cyc_t c;
        c = mk(OP_ADD, ST_FETCH);
        c.rst  = 1'b1;
        c.mark = mark;
        trace.push_back(c);
    endtask

    // drive one trace entry per cycle, sample on the falling edge
    task automatic run_trace();
        cyc_t e;
        obs_t got;
        while (trace.size() > 0) begin
            e        = trace.pop_front();
            rst      = e.rst;
            opcode   = e.opcode;
            im_ready = e.im_ready;
            dm_ready = e.dm_ready;
            br_taken = e.br_taken;
            @(negedge clk);
            got = {im_req, ir_write, dm_req, dm_we, rf_we, pc_write, pc_sel,
                   alu_src_a, alu_src_b, wb_sel, illegal};
            chk("outputs", 32'(got), 32'(e.exp));
            chk("state", 32'(state), 32'(e.st));
`ifdef CTRL_PERF_CNT_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("instret_cnt", instret_cnt, m_ret);
            if (e.mark) begin
                chk("cycle_cnt_10add", cycle_cnt, 32'd40);
                chk("instret_cnt_10add", instret_cnt, 32'd10);
            end
            if (e.rst) begin
                m_cyc = 32'd0;
                m_ret = 32'd0;
            end else begin
                if (e.st != ST_HALT) m_cyc = m_cyc + 32'd1;
                if (e.exp.pc_write)  m_ret = m_ret + 32'd1;
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] op;
        int imw, dmw, ab;
        rst      = 1'b1;
        opcode   = 7'd0;
        im_ready = 1'b0;
        dm_ready = 1'b0;
        br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state, then directed scenarios
        push_reset(1'b0);
        expand(OP_ADD, 0, 0, -1, -1);
        expand(OP_LW, 0, 2, -1, -1);
        expand(OP_BEQ, 0, 0, 1, -1);
        expand(OP_BEQ, 0, 0, 0, -1);
        expand(OP_JALR, 0, 0, -1, -1);
        expand(OP_BAD, 0, 0, -1, -1);
        expand(OP_ADD, 2, 0, -1, -1);
        expand(OP_SW, 0, 2, -1, 3);
        expand(OP_ADD, 0, 0, -1, -1);
        run_trace();

        // ten back-to-back adds from reset
        push_reset(1'b0);
        for (int i = 0; i < 10; i++) expand(OP_ADD, 0, 0, -1, -1);
        push_reset(1'b1);
        run_trace();

        // randomized instruction mix with wait-states and occasional mid-instruction resets
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 99) < 85) op = legal_ops[$urandom_range(0, 8)];
            else                            op = 7'($urandom);
            imw = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            dmw = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            expand(op, imw, dmw, -1, ab);
            run_trace();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
